alu_arbiter: RTL and testbench

Shares the single combinational `ALU` between two requesters (port 0: EXU main path, port 1: address/branch helper) over valid/ready handshakes. Each cycle at most one request is granted under round-robin, driven onto the ALU, and its result/zero flag registered into that port's one-entry response slot. The slot is held until the requester accepts it. The block sits between the decode/execute logic and the `ALU` instance. It drives `sel`/`a`/`b` and samples `result`/`is_zero`.

---
 rtl/alu_arbiter.sv | 98 +++++++++
 tb/tb_alu_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready ports.
// Optional statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int W    = 32,
  parameter int SELW = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0]      i_req_valid,
  output logic [1:0]      o_req_ready,
  input  logic [SELW-1:0] i_req_sel0,
  input  logic [SELW-1:0] i_req_sel1,
  input  logic [W-1:0]    i_req_a0,
  input  logic [W-1:0]    i_req_b0,
  input  logic [W-1:0]    i_req_a1,
  input  logic [W-1:0]    i_req_b1,
  output logic [1:0]      o_rsp_valid,
  input  logic [1:0]      i_rsp_ready,
  output logic [W-1:0]    o_rsp_result0,
  output logic [W-1:0]    o_rsp_result1,
  output logic            o_rsp_zero0,
  output logic            o_rsp_zero1,
  output logic [SELW-1:0] o_alu_sel,
  output logic [W-1:0]    o_alu_a,
  output logic [W-1:0]    o_alu_b,
  input  logic [W-1:0]    i_alu_result,
  input  logic            i_alu_zero,
  output logic [31:0]     o_cnt_grant0,
  output logic [31:0]     o_cnt_grant1,
  output logic [31:0]     o_cnt_conflict
);
  logic [1:0]   r_rsp_valid;
  logic [W-1:0] r_res0, r_res1;
  logic         r_zero0, r_zero1;
  logic         r_last;
  logic [1:0]   w_elig, w_gnt;

  // a full slot stays eligible when it drains in the same cycle
  always_comb begin
    w_elig      = i_req_valid & (~r_rsp_valid | i_rsp_ready) & {2{~i_rst}};
    w_gnt       = (&w_elig) ? (r_last ? 2'b01 : 2'b10) : w_elig;
    o_req_ready = w_gnt;
    o_alu_sel   = w_gnt[0] ? i_req_sel0 : w_gnt[1] ? i_req_sel1 : '0;
    o_alu_a     = w_gnt[0] ? i_req_a0   : w_gnt[1] ? i_req_a1   : '0;
    o_alu_b     = w_gnt[0] ? i_req_b0   : w_gnt[1] ? i_req_b1   : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= '0;
      r_res0      <= '0;
      r_res1      <= '0;
      r_zero0     <= 1'b0;
      r_zero1     <= 1'b0;
      r_last      <= 1'b1;
    end else begin
      if (|w_gnt) r_last <= w_gnt[1];
      if (w_gnt[0]) begin
        r_rsp_valid[0] <= 1'b1;
        r_res0         <= i_alu_result;
        r_zero0        <= i_alu_zero;
      end else if (i_rsp_ready[0]) r_rsp_valid[0] <= 1'b0;
      if (w_gnt[1]) begin
        r_rsp_valid[1] <= 1'b1;
        r_res1         <= i_alu_result;
        r_zero1        <= i_alu_zero;
      end else if (i_rsp_ready[1]) r_rsp_valid[1] <= 1'b0;
    end
  end

  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_result0 = r_res0;
  assign o_rsp_result1 = r_res1;
  assign o_rsp_zero0   = r_zero0;
  assign o_rsp_zero1   = r_zero1;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] r_cnt_g0, r_cnt_g1, r_cnt_c;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_g0 <= '0;
      r_cnt_g1 <= '0;
      r_cnt_c  <= '0;
    end else begin
      r_cnt_g0 <= r_cnt_g0 + 32'(w_gnt[0]);
      r_cnt_g1 <= r_cnt_g1 + 32'(w_gnt[1]);
      r_cnt_c  <= r_cnt_c + 32'(&w_elig);
    end
  end
  assign o_cnt_grant0   = r_cnt_g0;
  assign o_cnt_grant1   = r_cnt_g1;
  assign o_cnt_conflict = r_cnt_c;
`else
  assign o_cnt_grant0   = '0;
  assign o_cnt_grant1   = '0;
  assign o_cnt_conflict = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  localparam int W = 32, SELW = 4;
  logic clk = 1'b0, rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [SELW-1:0] sel0, sel1, alu_sel;
  logic [W-1:0] a0, b0, a1, b1, res0, res1, alu_a, alu_b, alu_result;
  logic z0, z1, alu_zero;
  logic [31:0] cg0, cg1, cc;
  int total = 0, bad = 0;
  bit m_v[2];
  logic [W-1:0] m_r[2];
  logic m_z[2];
  int m_last;
  logic [31:0] m_g0, m_g1, m_c;
  logic [W-1:0] held;

  alu_arbiter #(.W(W), .SELW(SELW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_sel0(sel0), .i_req_sel1(sel1), .i_req_a0(a0), .i_req_b0(b0),
    .i_req_a1(a1), .i_req_b1(b1), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result0(res0), .o_rsp_result1(res1), .o_rsp_zero0(z0), .o_rsp_zero1(z1),
    .o_alu_sel(alu_sel), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero),
    .o_cnt_grant0(cg0), .o_cnt_grant1(cg1), .o_cnt_conflict(cc)
  );

  // stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, anything else yields 0
  function automatic logic [W-1:0] alu_f(input logic [SELW-1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_sel, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slots();
    chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, m_v[1], m_v[0]});
    chk("rsp_result0", {32'd0, res0}, {32'd0, m_r[0]});
    chk("rsp_result1", {32'd0, res1}, {32'd0, m_r[1]});
    chk("rsp_zero0", {63'd0, z0}, {63'd0, m_z[0]});
    chk("rsp_zero1", {63'd0, z1}, {63'd0, m_z[1]});
`ifdef ALU_ARB_STATS_EN
    chk("cnt_grant0", {32'd0, cg0}, {32'd0, m_g0});
    chk("cnt_grant1", {32'd0, cg1}, {32'd0, m_g1});
    chk("cnt_conflict", {32'd0, cc}, {32'd0, m_c});
`else
    chk("cnt_off", {32'd0, cg0 | cg1 | cc}, 64'd0);
`endif
  endtask

  task automatic model_reset();
    m_v = '{0, 0}; m_r = '{'0, '0}; m_z = '{0, 0};
    m_last = 1; m_g0 = 0; m_g1 = 0; m_c = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    sel0 = '0; sel1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_reset();
    #1;
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    chk_slots();
    rst = 1'b0;
  endtask

  // one clock: inputs already driven; returns the granted port (-1 none)
  task automatic cyc(output int g);
    bit e0, e1;
    logic [W-1:0] exp_res;
    #1;
    e0 = req_valid[0] && (!m_v[0] || rsp_ready[0]);
    e1 = req_valid[1] && (!m_v[1] || rsp_ready[1]);
    g = (e0 && e1) ? 1 - m_last : e0 ? 0 : e1 ? 1 : -1;
    chk("req_ready", {62'd0, req_ready}, g < 0 ? 64'd0 : 64'd1 << g);
    chk("alu_sel", {60'd0, alu_sel}, g == 0 ? {60'd0, sel0} : g == 1 ? {60'd0, sel1} : 64'd0);
    chk("alu_a", {32'd0, alu_a}, g == 0 ? {32'd0, a0} : g == 1 ? {32'd0, a1} : 64'd0);
    chk("alu_b", {32'd0, alu_b}, g == 0 ? {32'd0, b0} : g == 1 ? {32'd0, b1} : 64'd0);
    exp_res = g == 0 ? alu_f(sel0, a0, b0) : alu_f(sel1, a1, b1);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (g == i) begin m_v[i] = 1; m_r[i] = exp_res; m_z[i] = (exp_res == '0); end
      else if (m_v[i] && rsp_ready[i]) m_v[i] = 0;
    end
    if (g >= 0) m_last = g;
    if (g == 0) m_g0++;
    if (g == 1) m_g1++;
    if (e0 && e1) m_c++;
    #1;
    chk_slots();
  endtask

  initial begin
    int g;
    do_reset();
    // single ADD on port 0
    req_valid = 2'b01; sel0 = 4'd0; a0 = 5; b0 = 7;
    cyc(g);
    chk("add_grant", 64'(g), 64'd0);
    chk("add_result", {32'd0, res0}, 64'd12);
    chk("add_zero", {63'd0, z0}, 64'd0);
    // subtract to zero on port 1
    req_valid = 2'b10; rsp_ready = 2'b01; sel1 = 4'd1; a1 = 9; b1 = 9;
    cyc(g);
    chk("sub_result", {32'd0, res1}, 64'd0);
    chk("sub_zero", {63'd0, z1}, 64'd1);
    // unsupported op code yields zero
    req_valid = 2'b10; rsp_ready = 2'b10; sel1 = 4'd9; a1 = 3; b1 = 4;
    cyc(g);
    chk("bad_op_result", {32'd0, res1}, 64'd0);
    // contention: strict alternation from a fresh reset
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 10; k++) begin
      sel0 = 4'($urandom_range(0, 4)); sel1 = 4'($urandom_range(0, 4));
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      cyc(g);
      chk("alternate", 64'(g), 64'(k % 2));
    end
`ifdef ALU_ARB_STATS_EN
    chk("contend_g0", {32'd0, cg0}, 64'd5);
    chk("contend_g1", {32'd0, cg1}, 64'd5);
    chk("contend_c", {32'd0, cc}, 64'd10);
`endif
    // backpressure on port 0
    do_reset();
    req_valid = 2'b01; sel0 = 4'd3; a0 = 32'hF0; b0 = 32'h0F;
    cyc(g);
    held = res0;
    chk("bp_first", {32'd0, held}, 64'hFF);
    req_valid = 2'b11; rsp_ready = 2'b10; sel0 = 4'd0; a0 = 1; b0 = 1;
    for (int k = 0; k < 3; k++) begin
      a1 = $urandom; b1 = $urandom; sel1 = 4'($urandom_range(0, 4));
      cyc(g);
      chk("bp_only_p1", 64'(g), 64'd1);
      chk("bp_hold", {32'd0, res0}, {32'd0, held});
    end
    rsp_ready = 2'b11;
    cyc(g);
    chk("bp_release", 64'(g), 64'd0);
    chk("bp_new_res", {32'd0, res0}, 64'd2);
    // reset one cycle after a grant, before the response is taken
    do_reset();
    req_valid = 2'b01; sel0 = 4'd0; a0 = 100; b0 = 23;
    cyc(g);
    req_valid = 2'b11; rsp_ready = 2'b00;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {62'd0, rsp_valid}, 64'd0);
    chk("mid_rst_res0", {32'd0, res0}, 64'd0);
    chk("mid_rst_ready", {62'd0, req_ready}, 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 2'b11; a0 = 1; b0 = 2; a1 = 3; b1 = 4;
    cyc(g);
    chk("post_rst_first", 64'(g), 64'd0);
    // random traffic
    for (int k = 0; k < 400; k++) begin
      req_valid = 2'($urandom); rsp_ready = 2'($urandom);
      sel0 = 4'($urandom_range(0, 7)); sel1 = 4'($urandom_range(0, 7));
      a0 = $urandom_range(0, 7); b0 = $urandom_range(0, 7);
      a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      cyc(g);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
